// File: rtl/hack_alu.sv
// rtl/hack_alu.sv - Hack ALU with one registered output stage; optional cy/ov outputs under HACK_ALU_FLAGS_EN
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid
`ifdef HACK_ALU_FLAGS_EN
  ,
  output logic             cy,
  output logic             ov
`endif
);

  logic [WIDTH-1:0] x1, x2, y1, y2;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] o;

  // Operand conditioning: zero first, then invert.
  always_comb begin
    x1 = zx ? '0 : x;
    x2 = nx ? ~x1 : x1;
    y1 = zy ? '0 : y;
    y2 = ny ? ~y1 : y1;
  end

`ifdef HACK_ALU_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic           cy_d;
  logic           ov_d;

  always_comb begin
    sum_ext = {1'b0, x2} + {1'b0, y2};
    sum     = sum_ext[WIDTH-1:0];
    cy_d    = f & sum_ext[WIDTH];
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    ov_d    = f & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);
  end
`else
  always_comb begin
    sum = x2 + y2;
  end
`endif

  always_comb begin
    r = f ? sum : (x2 & y2);
    o = no ? ~r : r;
  end

  // Outputs only load under in_valid, so unknown controls on idle cycles are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      zr        <= 1'b1;
      ng        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= o;
        zr  <= (o == '0);
        ng  <= o[WIDTH-1];
      end
    end
  end

`ifdef HACK_ALU_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy <= 1'b0;
      ov <= 1'b0;
    end else if (in_valid) begin
      cy <= cy_d;
      ov <= ov_d;
    end
  end
`endif

endmodule

// File: tb/tb_hack_alu.sv
// tb/tb_hack_alu.sv - scoreboard bench for hack_alu against an arithmetic reference model
module tb_hack_alu;

  localparam int W = 16;
  localparam longint M = 64'd65536;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
  logic [W-1:0] out;
  logic         zr, ng, out_valid;
`ifdef HACK_ALU_FLAGS_EN
  logic         cy, ov;
`endif

  hack_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out(out), .zr(zr), .ng(ng), .out_valid(out_valid)
`ifdef HACK_ALU_FLAGS_EN
    , .cy(cy), .ov(ov)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    logic [W-1:0] o;
    bit           zr;
    bit           ng;
    bit           cy;
    bit           ov;
  } rec_t;

  rec_t sb[$];
  rec_t held;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference computed from integer arithmetic over the operand values.
  function automatic rec_t model(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic [5:0] c);
    rec_t   rr;
    longint xa, ya, res, sx, sy, ss;
    xa = c[5] ? 0 : longint'(xi);
    if (c[4]) xa = M - 1 - xa;
    ya = c[3] ? 0 : longint'(yi);
    if (c[2]) ya = M - 1 - ya;
    res = c[1] ? (xa + ya) % M : (xa & ya);
    if (c[0]) res = M - 1 - res;
    sx = (xa >= M / 2) ? xa - M : xa;
    sy = (ya >= M / 2) ? ya - M : ya;
    ss = sx + sy;
    rr.v  = 1'b1;
    rr.o  = W'(res);
    rr.zr = (res == 0);
    rr.ng = (res >= M / 2);
    rr.cy = c[1] && ((xa + ya) >= M);
    rr.ov = c[1] && ((ss > M / 2 - 1) || (ss < -(M / 2)));
    return rr;
  endfunction

  task automatic issue(input bit v, input logic [W-1:0] xi, input logic [W-1:0] yi, input logic [5:0] c);
    rec_t rr;
    @(negedge clk);
    in_valid = v;
    x = xi; y = yi;
    {zx, nx, zy, ny, f, no} = c;
    @(posedge clk);
    if (v) begin
      rr = model(xi, yi, c);
      held = rr;
    end else begin
      rr = held;
      rr.v = 1'b0;
    end
    sb.push_back(rr);
  endtask

  // Monitor: one expected record per clock once stimulus is flowing.
  always @(negedge clk) begin
    rec_t e;
    if (!rst) begin
      if (sb.size() == 0) begin
        if (out_valid) chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.v));
        chk(e.v ? "out" : "out_hold", 32'(out), 32'(e.o));
        chk("zr", 32'(zr), 32'(e.zr));
        chk("ng", 32'(ng), 32'(e.ng));
`ifdef HACK_ALU_FLAGS_EN
        chk("cy", 32'(cy), 32'(e.cy));
        chk("ov", 32'(ov), 32'(e.ov));
`endif
      end
    end
  end

  task automatic reset_held();
    held.v = 1'b0; held.o = '0; held.zr = 1'b1; held.ng = 1'b0; held.cy = 1'b0; held.ov = 1'b0;
  endtask

  initial begin
    logic [5:0] codes [0:14];
    logic [W-1:0] xs [0:14];
    logic [W-1:0] ys [0:14];
    codes = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
              6'b001111, 6'b110011, 6'b000010, 6'b010011, 6'b000111, 6'b011111,
              6'b001110, 6'b000000, 6'b010101};
    for (int i = 0; i < 15; i++) begin
      xs[i] = (i < 8) ? 16'h0000 : 16'h0011;
      ys[i] = (i < 8) ? 16'hFFFF : 16'h0003;
    end
    reset_held();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_zr", 32'(zr), 32'd1);
    chk("reset_ng", 32'(ng), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed Hack codes back to back, then an idle cycle to show hold.
    for (int i = 0; i < 15; i++) issue(1'b1, xs[i], ys[i], codes[i]);
    issue(1'b0, 16'h1234, 16'h5678, 6'b011111);
    issue(1'b0, 16'hFFFF, 16'h0001, 6'b000010);

    // Asynchronous reset in the middle of the cycle holding 0x0014.
    issue(1'b1, 16'h0011, 16'h0003, 6'b000010);
    #6;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_zr", 32'(zr), 32'd1);
    chk("async_rst_ng", 32'(ng), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    reset_held();
    @(negedge clk);
    rst = 1'b0;

`ifdef HACK_ALU_FLAGS_EN
    issue(1'b1, 16'h7FFF, 16'h0001, 6'b000010);
    issue(1'b1, 16'hFFFF, 16'h0001, 6'b000010);
    issue(1'b1, 16'h8000, 16'h8000, 6'b000010);
`endif

    // Random traffic, including non-canonical control codes and idle gaps.
    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 6'($urandom));
    end

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
